// File: rtl/alu_share_arb.sv
// ----------------------------------------------------------------------------
// alu_share_arb
//
// Lets two requesters share one execute-stage datapath (operand mux, ALU,
// registered result and write-select). One requester is granted at a time:
// its operand bundle is captured and driven into the stage, the stage
// latency is waited out, then the result and write-select are captured and
// returned to the owner with a one-cycle done pulse.
//
// Parameters
//   LAT                  execute-stage latency in cycles (1..4)
//
// Configuration macro
//   ALU_ARB_FIXED_PRIO_EN  defined: requester 0 always wins a tie
//                          (requester 1 can starve). Undefined (default):
//                          round-robin on tie using the last winner.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   req0/req1                         level requests
//   rdata1_x, rdata2_x, imm_x,
//   datasrc_x, aop_x, ws_x            operand bundle of requester x
//   gnt0/gnt1                         one-cycle grant pulse (issue cycle)
//   rdata1, rdata2, imm, datasrc,
//   aop, ws                           captured operands to the execute stage
//   alu_vld                           high in the issue cycle only
//   alu_out, wtsel                    registered stage result / write-select
//   res, res_ws                       captured result for the owner
//   done0/done1                       one-cycle result-valid pulse
//   busy                              high whenever the sequencer is not idle
// ----------------------------------------------------------------------------
module alu_share_arb #(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] rdata1_0,
    input  logic [31:0] rdata2_0,
    input  logic [31:0] rdata1_1,
    input  logic [31:0] rdata2_1,
    input  logic [15:0] imm_0,
    input  logic [15:0] imm_1,
    input  logic        datasrc_0,
    input  logic        datasrc_1,
    input  logic [2:0]  aop_0,
    input  logic [2:0]  aop_1,
    input  logic [4:0]  ws_0,
    input  logic [4:0]  ws_1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    output logic [15:0] imm,
    output logic        datasrc,
    output logic [2:0]  aop,
    output logic [4:0]  ws,
    output logic        alu_vld,
    input  logic [31:0] alu_out,
    input  logic [4:0]  wtsel,
    output logic [31:0] res,
    output logic [4:0]  res_ws,
    output logic        done0,
    output logic        done1,
    output logic        busy
);

    if (LAT < 1 || LAT > 4) begin : g_lat_check
        $error("alu_share_arb: LAT must be in 1..4");
    end

    localparam logic [2:0] CNT_INIT = 3'(LAT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t      state_reg, state_next;
    logic        owner_reg, owner_next;
    logic        last_reg, last_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic        capture_ops, capture_res;
    logic        winner;
    logic        any_req;

    logic [31:0] rdata1_reg, rdata2_reg, res_reg;
    logic [15:0] imm_reg;
    logic        datasrc_reg;
    logic [2:0]  aop_reg;
    logic [4:0]  ws_reg, res_ws_reg;

    logic [1:0]  gnt_vec, done_vec;

    // Winner selection. A lone requester always wins; on a tie the
    // requester that did not win last time goes first (round-robin),
    // unless fixed priority is configured.
    always_comb begin
        any_req = req0 | req1;
`ifdef ALU_ARB_FIXED_PRIO_EN
        winner = ~req0;
`else
        if (req0 && req1) begin
            winner = ~last_reg;
        end else begin
            winner = ~req0;
        end
`endif
    end

    always_comb begin
        state_next  = state_reg;
        owner_next  = owner_reg;
        last_next   = last_reg;
        cnt_next    = cnt_reg;
        capture_ops = 1'b0;
        capture_res = 1'b0;
        case (state_reg)
            // DONE arbitrates exactly like IDLE so continuous requests run
            // back to back without an idle bubble.
            IDLE, DONE: begin
                if (any_req) begin
                    state_next  = ISSUE;
                    owner_next  = winner;
                    last_next   = winner;
                    capture_ops = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            ISSUE: begin
                state_next = WAIT;
                cnt_next   = CNT_INIT;
            end
            WAIT: begin
                if (cnt_reg == 3'd0) begin
                    capture_res = 1'b1;
                    state_next  = DONE;
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            owner_reg   <= 1'b0;
            last_reg    <= 1'b1;
            cnt_reg     <= 3'd0;
            rdata1_reg  <= '0;
            rdata2_reg  <= '0;
            imm_reg     <= '0;
            datasrc_reg <= 1'b0;
            aop_reg     <= '0;
            ws_reg      <= '0;
            res_reg     <= '0;
            res_ws_reg  <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            last_reg  <= last_next;
            cnt_reg   <= cnt_next;
            if (capture_ops) begin
                rdata1_reg  <= winner ? rdata1_1  : rdata1_0;
                rdata2_reg  <= winner ? rdata2_1  : rdata2_0;
                imm_reg     <= winner ? imm_1     : imm_0;
                datasrc_reg <= winner ? datasrc_1 : datasrc_0;
                aop_reg     <= winner ? aop_1     : aop_0;
                ws_reg      <= winner ? ws_1      : ws_0;
            end
            if (capture_res) begin
                res_reg    <= alu_out;
                res_ws_reg <= wtsel;
            end
        end
    end

    // Per-requester grant/done pulses, steered by the current owner.
    for (genvar gi = 0; gi < 2; gi++) begin : g_owner
        assign gnt_vec[gi]  = (state_reg == ISSUE) && (owner_reg == 1'(gi));
        assign done_vec[gi] = (state_reg == DONE)  && (owner_reg == 1'(gi));
    end

    assign gnt0    = gnt_vec[0];
    assign gnt1    = gnt_vec[1];
    assign done0   = done_vec[0];
    assign done1   = done_vec[1];
    assign alu_vld = (state_reg == ISSUE);
    assign busy    = (state_reg != IDLE);

    // Operand registers drive the stage continuously; an enable-less stage
    // simply recomputes the same result every cycle.
    assign rdata1  = rdata1_reg;
    assign rdata2  = rdata2_reg;
    assign imm     = imm_reg;
    assign datasrc = datasrc_reg;
    assign aop     = aop_reg;
    assign ws      = ws_reg;
    assign res     = res_reg;
    assign res_ws  = res_ws_reg;

endmodule

// File: tb/tb_alu_share_arb.sv
// ----------------------------------------------------------------------------
// tb_alu_share_arb
//
// Two instances: dut_a with LAT=1 and dut_b with LAT=4, each behind a
// stage stub computing alu_out = rdata1 + rdata2 and wtsel = ws with LAT
// registered cycles of delay. Expected results are queued when a request is
// driven and popped when the corresponding done pulse appears.
// Cycle numbering inside a scenario: cycle 0 is the cycle the request is
// first presented; outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_alu_share_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] r1_0, r2_0, r1_1, r2_1;
    logic [15:0] imm_0, imm_1;
    logic        ds_0, ds_1;
    logic [2:0]  aop_0, aop_1;
    logic [4:0]  ws_0, ws_1;
    logic        req0_a, req1_a, req0_b, req1_b;

    logic        a_gnt0, a_gnt1, a_done0, a_done1, a_vld, a_busy, a_ds;
    logic [31:0] a_r1, a_r2, a_res, a_alu_out;
    logic [15:0] a_imm;
    logic [2:0]  a_aop;
    logic [4:0]  a_ws, a_res_ws, a_wtsel;

    logic        b_gnt0, b_gnt1, b_done0, b_done1, b_vld, b_busy, b_ds;
    logic [31:0] b_r1, b_r2, b_res, b_alu_out;
    logic [15:0] b_imm;
    logic [2:0]  b_aop;
    logic [4:0]  b_ws, b_res_ws, b_wtsel;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        own;
        logic [31:0] res;
        logic [4:0]  ws;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];

    alu_share_arb #(.LAT(1)) dut_a (
        .clk(clk), .rst(rst), .req0(req0_a), .req1(req1_a),
        .rdata1_0(r1_0), .rdata2_0(r2_0), .rdata1_1(r1_1), .rdata2_1(r2_1),
        .imm_0(imm_0), .imm_1(imm_1), .datasrc_0(ds_0), .datasrc_1(ds_1),
        .aop_0(aop_0), .aop_1(aop_1), .ws_0(ws_0), .ws_1(ws_1),
        .gnt0(a_gnt0), .gnt1(a_gnt1), .rdata1(a_r1), .rdata2(a_r2),
        .imm(a_imm), .datasrc(a_ds), .aop(a_aop), .ws(a_ws), .alu_vld(a_vld),
        .alu_out(a_alu_out), .wtsel(a_wtsel), .res(a_res), .res_ws(a_res_ws),
        .done0(a_done0), .done1(a_done1), .busy(a_busy)
    );

    alu_share_arb #(.LAT(4)) dut_b (
        .clk(clk), .rst(rst), .req0(req0_b), .req1(req1_b),
        .rdata1_0(r1_0), .rdata2_0(r2_0), .rdata1_1(r1_1), .rdata2_1(r2_1),
        .imm_0(imm_0), .imm_1(imm_1), .datasrc_0(ds_0), .datasrc_1(ds_1),
        .aop_0(aop_0), .aop_1(aop_1), .ws_0(ws_0), .ws_1(ws_1),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .rdata1(b_r1), .rdata2(b_r2),
        .imm(b_imm), .datasrc(b_ds), .aop(b_aop), .ws(b_ws), .alu_vld(b_vld),
        .alu_out(b_alu_out), .wtsel(b_wtsel), .res(b_res), .res_ws(b_res_ws),
        .done0(b_done0), .done1(b_done1), .busy(b_busy)
    );

    // Execute-stage stubs.
    always @(posedge clk) begin
        a_alu_out <= a_r1 + a_r2;
        a_wtsel   <= a_ws;
    end

    logic [31:0] b_pipe [4];
    logic [4:0]  b_wpipe [4];
    always @(posedge clk) begin
        b_pipe[0]  <= b_r1 + b_r2;
        b_wpipe[0] <= b_ws;
        for (int i = 1; i < 4; i++) begin
            b_pipe[i]  <= b_pipe[i-1];
            b_wpipe[i] <= b_wpipe[i-1];
        end
    end
    assign b_alu_out = b_pipe[3];
    assign b_wtsel   = b_wpipe[3];

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({a_gnt0, a_gnt1, a_done0, a_done1, a_vld, a_busy} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl_a got=%b exp=000000",
                     {a_gnt0, a_gnt1, a_done0, a_done1, a_vld, a_busy});
        end
        n_checks++;
        if ({a_r1, a_r2, a_imm, a_ds, a_aop, a_ws} !== '0) begin
            n_fail++;
            $display("FAIL reset_ops_a got r1=%h r2=%h imm=%h ds=%b aop=%h ws=%h exp all 0",
                     a_r1, a_r2, a_imm, a_ds, a_aop, a_ws);
        end
        n_checks++;
        if ({a_res, a_res_ws} !== '0) begin
            n_fail++;
            $display("FAIL reset_res_a got res=%h res_ws=%h exp 0", a_res, a_res_ws);
        end
        n_checks++;
        if ({b_gnt0, b_gnt1, b_done0, b_done1, b_vld, b_busy} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl_b got=%b exp=000000",
                     {b_gnt0, b_gnt1, b_done0, b_done1, b_vld, b_busy});
        end
        n_checks++;
        if ({b_r1, b_r2, b_imm, b_ds, b_aop, b_ws, b_res, b_res_ws} !== '0) begin
            n_fail++;
            $display("FAIL reset_data_b got r1=%h r2=%h ws=%h res=%h res_ws=%h exp all 0",
                     b_r1, b_r2, b_ws, b_res, b_res_ws);
        end
        $display("txn reset: outputs checked");
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_a.delete();
        sb_b.delete();
    endtask

    task automatic test_single_lat1();
        exp_t e;
        r1_0 = 32'd5; r2_0 = 32'd7; ws_0 = 5'd3; ds_0 = 1'b0; aop_0 = 3'd0; imm_0 = 16'd0;
        req0_a = 1'b1;
        sb_a.push_back('{own: 1'b0, res: 32'd12, ws: 5'd3});
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (a_gnt0 !== (c == 1)) begin
                n_fail++; $display("FAIL single_gnt0 cycle=%0d got=%b exp=%b", c, a_gnt0, (c == 1));
            end
            n_checks++;
            if (a_busy !== (c >= 1 && c <= 3)) begin
                n_fail++; $display("FAIL single_busy cycle=%0d got=%b exp=%b", c, a_busy, (c >= 1 && c <= 3));
            end
            n_checks++;
            if (a_done0 !== (c == 3)) begin
                n_fail++; $display("FAIL single_done0 cycle=%0d got=%b exp=%b", c, a_done0, (c == 3));
            end
            n_checks++;
            if (a_done1 !== 1'b0) begin
                n_fail++; $display("FAIL single_done1 cycle=%0d got=%b exp=0", c, a_done1);
            end
            if (c == 1) begin
                n_checks++;
                if ({a_vld, a_r1, a_r2, a_ws} !== {1'b1, 32'd5, 32'd7, 5'd3}) begin
                    n_fail++; $display("FAIL single_issue got vld=%b r1=%0d r2=%0d ws=%0d exp 1 5 7 3",
                                       a_vld, a_r1, a_r2, a_ws);
                end
                req0_a = 1'b0;
            end
            if (a_done0 || a_done1) begin
                n_checks++;
                if (sb_a.size() == 0) begin
                    n_fail++; $display("FAIL single_sb unexpected done at cycle %0d", c);
                end else begin
                    e = sb_a.pop_front();
                    if ({a_done1, a_res, a_res_ws} !== {e.own, e.res, e.ws}) begin
                        n_fail++;
                        $display("FAIL single_result got own=%0d res=%h ws=%0d exp own=%0d res=%h ws=%0d",
                                 a_done1, a_res, a_res_ws, e.own, e.res, e.ws);
                    end
                    $display("txn single: done%0d res=%h ws=%0d cycle=%0d", a_done1, a_res, a_res_ws, c);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_round_robin();
        exp_t e;
        logic exp_g [3];
        int   g = 0;
        int   nd = 0;
        int   last_done = -1;
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_g = '{1'b0, 1'b0, 1'b0};
`else
        exp_g = '{1'b0, 1'b1, 1'b0};
`endif
        r1_0 = 32'd10; r2_0 = 32'd1; ws_0 = 5'd1;
        r1_1 = 32'd20; r2_1 = 32'd2; ws_1 = 5'd2;
        req0_a = 1'b1; req1_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb_a.push_back('{own: exp_g[i], res: (exp_g[i] ? 32'd22 : 32'd11),
                             ws: (exp_g[i] ? 5'd2 : 5'd1)});
        end
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            if (a_gnt0 || a_gnt1) begin
                n_checks++;
                if (g > 2) begin
                    n_fail++; $display("FAIL rr_extra_grant cycle=%0d got gnt1=%b exp no grant", c, a_gnt1);
                end else if (a_gnt1 !== exp_g[g]) begin
                    n_fail++; $display("FAIL rr_grant idx=%0d got=%0d exp=%0d", g, a_gnt1, exp_g[g]);
                end
                $display("txn rr: grant%0d cycle=%0d", a_gnt1, c);
                g++;
                if (g == 3) begin
                    req0_a = 1'b0; req1_a = 1'b0;
                end
            end
            if (a_done0 || a_done1) begin
                n_checks++;
                if (sb_a.size() == 0) begin
                    n_fail++; $display("FAIL rr_sb unexpected done at cycle %0d", c);
                end else begin
                    e = sb_a.pop_front();
                    if ({a_done1, a_res, a_res_ws} !== {e.own, e.res, e.ws}) begin
                        n_fail++;
                        $display("FAIL rr_result got own=%0d res=%h ws=%0d exp own=%0d res=%h ws=%0d",
                                 a_done1, a_res, a_res_ws, e.own, e.res, e.ws);
                    end
                end
                if (nd > 0) begin
                    n_checks++;
                    if (c - last_done != 3) begin
                        n_fail++; $display("FAIL rr_spacing got=%0d exp=3", c - last_done);
                    end
                end
                last_done = c;
                nd++;
            end
            n_checks++;
            if (a_busy !== (c >= 1 && c <= 9)) begin
                n_fail++; $display("FAIL rr_busy cycle=%0d got=%b exp=%b", c, a_busy, (c >= 1 && c <= 9));
            end
        end
        n_checks++;
        if (g != 3 || nd != 3) begin
            n_fail++; $display("FAIL rr_counts got grants=%0d dones=%0d exp 3 3", g, nd);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_lat4();
        exp_t e;
        r1_1 = 32'hFFFF_FFFF; r2_1 = 32'd1; ws_1 = 5'd9;
        req1_b = 1'b1;
        sb_b.push_back('{own: 1'b1, res: 32'h0000_0000, ws: 5'd9});
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            n_checks++;
            if ({b_gnt1, b_done1} !== {(c == 1), (c == 6)}) begin
                n_fail++; $display("FAIL lat4_pulses cycle=%0d got gnt1=%b done1=%b exp %b %b",
                                   c, b_gnt1, b_done1, (c == 1), (c == 6));
            end
            n_checks++;
            if ({b_gnt0, b_done0} !== 2'b00) begin
                n_fail++; $display("FAIL lat4_req0_side cycle=%0d got gnt0=%b done0=%b exp 0 0", c, b_gnt0, b_done0);
            end
            n_checks++;
            if (b_busy !== (c >= 1 && c <= 6)) begin
                n_fail++; $display("FAIL lat4_busy cycle=%0d got=%b exp=%b", c, b_busy, (c >= 1 && c <= 6));
            end
            if (c >= 1 && c <= 6) begin
                n_checks++;
                if ({b_r1, b_r2, b_ws} !== {32'hFFFF_FFFF, 32'd1, 5'd9}) begin
                    n_fail++; $display("FAIL lat4_ops_stable cycle=%0d got r1=%h r2=%h ws=%0d exp ffffffff 1 9",
                                       c, b_r1, b_r2, b_ws);
                end
            end
            if (c == 1) req1_b = 1'b0;
            if (c == 2) begin
                r1_1 = 32'h0000_1234; r2_1 = 32'd5; ws_1 = 5'd0;
            end
            if (b_done0 || b_done1) begin
                n_checks++;
                if (sb_b.size() == 0) begin
                    n_fail++; $display("FAIL lat4_sb unexpected done at cycle %0d", c);
                end else begin
                    e = sb_b.pop_front();
                    if ({b_done1, b_res, b_res_ws} !== {e.own, e.res, e.ws}) begin
                        n_fail++;
                        $display("FAIL lat4_result got own=%0d res=%h ws=%0d exp own=%0d res=%h ws=%0d",
                                 b_done1, b_res, b_res_ws, e.own, e.res, e.ws);
                    end
                    $display("txn lat4: done%0d res=%h ws=%0d cycle=%0d", b_done1, b_res, b_res_ws, c);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_bundle_change();
        exp_t e;
        r1_0 = 32'd100; r2_0 = 32'd23; ws_0 = 5'd12;
        req0_a = 1'b1;
        sb_a.push_back('{own: 1'b0, res: 32'd123, ws: 5'd12});
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            n_checks++;
            if ({a_gnt0, a_done0} !== {(c == 1), (c == 3)}) begin
                n_fail++; $display("FAIL change_pulses cycle=%0d got gnt0=%b done0=%b exp %b %b",
                                   c, a_gnt0, a_done0, (c == 1), (c == 3));
            end
            if (c == 1) req0_a = 1'b0;
            if (c == 2) begin
                r1_0 = 32'd999; r2_0 = 32'd1; ws_0 = 5'd30;
            end
            if (a_done0 || a_done1) begin
                n_checks++;
                if (sb_a.size() == 0) begin
                    n_fail++; $display("FAIL change_sb unexpected done at cycle %0d", c);
                end else begin
                    e = sb_a.pop_front();
                    if ({a_done1, a_res, a_res_ws} !== {e.own, e.res, e.ws}) begin
                        n_fail++;
                        $display("FAIL change_result got own=%0d res=%h ws=%0d exp own=%0d res=%h ws=%0d",
                                 a_done1, a_res, a_res_ws, e.own, e.res, e.ws);
                    end
                    $display("txn change: done%0d res=%h ws=%0d", a_done1, a_res, a_res_ws);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        r1_0 = 32'd100; r2_0 = 32'd200; ws_0 = 5'd4;
        req0_a = 1'b1;
        sb_a.push_back('{own: 1'b0, res: 32'd300, ws: 5'd4});
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            n_checks++;
            if ({a_done0, a_done1} !== 2'b00) begin
                n_fail++; $display("FAIL rstmid_no_done cycle=%0d got done0=%b done1=%b exp 0 0", c, a_done0, a_done1);
            end
            if (c == 1) begin
                n_checks++;
                if (a_gnt0 !== 1'b1) begin
                    n_fail++; $display("FAIL rstmid_gnt0 got=%b exp=1", a_gnt0);
                end
                req0_a = 1'b0;
            end
            if (c == 2) begin
                rst = 1'b1;
                sb_a.delete();
            end
            if (c == 3) begin
                n_checks++;
                if ({a_gnt0, a_gnt1, a_vld, a_busy, a_r1, a_r2, a_imm, a_ds, a_aop, a_ws, a_res, a_res_ws} !== '0) begin
                    n_fail++;
                    $display("FAIL rstmid_zero got busy=%b vld=%b r1=%h r2=%h ws=%0d res=%h res_ws=%0d exp all 0",
                             a_busy, a_vld, a_r1, a_r2, a_ws, a_res, a_res_ws);
                end
                rst = 1'b0;
            end
        end
        $display("txn rstmid: in-flight op discarded");
        @(posedge clk);
        #1;
        r1_0 = 32'd1; r2_0 = 32'd2; ws_0 = 5'd5;
        req0_a = 1'b1;
        sb_a.push_back('{own: 1'b0, res: 32'd3, ws: 5'd5});
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            n_checks++;
            if ({a_gnt0, a_done0} !== {(c == 1), (c == 3)}) begin
                n_fail++; $display("FAIL rstmid_fresh_pulses cycle=%0d got gnt0=%b done0=%b exp %b %b",
                                   c, a_gnt0, a_done0, (c == 1), (c == 3));
            end
            if (c == 1) req0_a = 1'b0;
            if (a_done0 || a_done1) begin
                n_checks++;
                if (sb_a.size() == 0) begin
                    n_fail++; $display("FAIL rstmid_sb unexpected done at cycle %0d", c);
                end else begin
                    e = sb_a.pop_front();
                    if ({a_done1, a_res, a_res_ws} !== {e.own, e.res, e.ws}) begin
                        n_fail++;
                        $display("FAIL rstmid_fresh_result got own=%0d res=%h ws=%0d exp own=%0d res=%h ws=%0d",
                                 a_done1, a_res, a_res_ws, e.own, e.res, e.ws);
                    end
                    $display("txn rstmid fresh: done%0d res=%h ws=%0d", a_done1, a_res, a_res_ws);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        r1_1 = 32'd7; r2_1 = 32'd8; ws_1 = 5'd6;
        req1_a = 1'b1;
        sb_a.push_back('{own: 1'b1, res: 32'd15, ws: 5'd6});
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            n_checks++;
            if ({a_gnt1, a_done1} !== {(c == 1 || c == 4), (c == 3 || c == 6)}) begin
                n_fail++; $display("FAIL b2b_pulses cycle=%0d got gnt1=%b done1=%b exp %b %b",
                                   c, a_gnt1, a_done1, (c == 1 || c == 4), (c == 3 || c == 6));
            end
            n_checks++;
            if ({a_gnt0, a_done0} !== 2'b00) begin
                n_fail++; $display("FAIL b2b_req0_side cycle=%0d got gnt0=%b done0=%b exp 0 0", c, a_gnt0, a_done0);
            end
            n_checks++;
            if (a_busy !== (c >= 1 && c <= 6)) begin
                n_fail++; $display("FAIL b2b_busy cycle=%0d got=%b exp=%b", c, a_busy, (c >= 1 && c <= 6));
            end
            if (c == 1) begin
                r1_1 = 32'd30; r2_1 = 32'd40; ws_1 = 5'd7;
                sb_a.push_back('{own: 1'b1, res: 32'd70, ws: 5'd7});
            end
            if (c == 4) req1_a = 1'b0;
            if (a_done0 || a_done1) begin
                n_checks++;
                if (sb_a.size() == 0) begin
                    n_fail++; $display("FAIL b2b_sb unexpected done at cycle %0d", c);
                end else begin
                    e = sb_a.pop_front();
                    if ({a_done1, a_res, a_res_ws} !== {e.own, e.res, e.ws}) begin
                        n_fail++;
                        $display("FAIL b2b_result got own=%0d res=%h ws=%0d exp own=%0d res=%h ws=%0d",
                                 a_done1, a_res, a_res_ws, e.own, e.res, e.ws);
                    end
                    $display("txn b2b: done%0d res=%h ws=%0d cycle=%0d", a_done1, a_res, a_res_ws, c);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        r1_0 = '0; r2_0 = '0; r1_1 = '0; r2_1 = '0;
        imm_0 = '0; imm_1 = '0; ds_0 = 1'b0; ds_1 = 1'b0;
        aop_0 = '0; aop_1 = '0; ws_0 = '0; ws_1 = '0;
        req0_a = 1'b0; req1_a = 1'b0; req0_b = 1'b0; req1_b = 1'b0;

        test_reset();
        test_single_lat1();
        test_reset();
        test_round_robin();
        test_lat4();
        test_bundle_change();
        test_reset_mid();
        test_back_to_back();

        n_checks++;
        if (sb_a.size() != 0 || sb_b.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drained got a=%0d b=%0d exp 0 0", sb_a.size(), sb_b.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Arbiter and sequencer that lets two requesters share the single execute-stage datapath (operand mux, ALU, registered result and write-select). It sits between two operation sources (e.g. the main pipeline decode and a debug/microcode port) and the execute stage. It grants one requester at a time, drives captured operands into the stage, waits out the stage latency, then returns the result and write-select to the owner with a one-cycle done pulse.

## Interface
- LAT, 1: execute-stage latency in cycles, from operands driven to `alu_out` valid; legal range 1..4.

- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- req0 / req1  in  1  level request from requester 0 / 1.
- rdata1_0, rdata2_0 / rdata1_1, rdata2_1  in  32  operands from requester 0 / 1.
- imm_0 / imm_1  in  16  immediate.
- datasrc_0 / datasrc_1  in  1  operand-B select (0 = rdata2, 1 = imm).
- aop_0 / aop_1  in  3  ALU opcode.
- ws_0 / ws_1  in  5  destination register select.
- gnt0 / gnt1  out  1  one-cycle grant pulse; operands were captured.
- rdata1, rdata2  out  32  operands to execute stage.
- imm  out  16; datasrc  out  1; aop  out  3; ws  out  5: control to execute stage.
- alu_vld  out  1  high during the issue cycle only.
- alu_out  in  32; wtsel  in  5: registered stage result and write-select.
- res  out  32; res_ws  out  5: captured result and write-select for the owner.
- done0 / done1  out  1  one-cycle result-valid pulse to the owner.
- busy  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, DONE. Arbitration happens only in IDLE and DONE.
- Arbitration edge (IDLE or DONE, some req high): winner's operand bundle is captured into operand registers, `owner <= winner`, `last <= winner`, and the winner's gnt goes high next cycle. State goes to ISSUE.
- In IDLE or DONE with no req, the next state is IDLE.
- Round-robin on tie: the requester not equal to `last` wins. A single requester always wins.
- ISSUE: `alu_vld` = 1 and gnt pulse high. Next state is WAIT, with `cnt <= LAT-1`.
- WAIT: if `cnt == 0`, capture `res <= alu_out`, `res_ws <= wtsel`, and go to DONE. Otherwise decrement `cnt`.
- DONE: `done[owner]` is high for exactly one cycle.
- Stage-facing outputs hold the operand registers at all times, so a stage without an enable recomputes an identical result every cycle.
- `res`/`res_ws` hold their last values until the next capture.
- Request protocol:
  - Requester holds its bundle stable while req is high and not yet granted.
  - It deasserts req in the gnt cycle.
  - A req still high in its own DONE cycle is a new request.
- Req withdrawn before being sampled: no grant, no effect.
- `cnt` is 3 bits and never wraps. LAT outside 1..4 is an elaboration error.

## Timing
- Req sampled at edge E0 → gnt and `alu_vld` high in cycle 1 → done high in cycle LAT+2 → next grant can be issued at the edge ending the DONE cycle (back-to-back, no idle bubble).
- Throughput: one operation per LAT+2 cycles under continuous requests.
- `busy` is high from cycle 1 through the DONE cycle; it stays high across back-to-back operations.
- Reset values: state IDLE, `last` = 1 (requester 0 wins first tie), owner 0, cnt 0. All outputs are 0: gnt0/1, done0/1, alu_vld, busy, rdata1, rdata2, imm, datasrc, aop, ws, res, res_ws.
- Reset mid-operation: the in-flight operation is discarded, no done is issued, and the requester must re-request.
- rst has priority over every other event in the same cycle.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN` defined: requester 0 always wins a tie, `last` is ignored, and requester 1 can starve.
- `ALU_ARB_FIXED_PRIO_EN` undefined (default): round-robin as above.

## Test plan
Bench stub models the execute stage with `alu_out = rdata1 + rdata2` (datasrc=0), registered with LAT cycles of delay; `wtsel = ws` on the same delay.

- Reset then single op, LAT=1:
  - Stimulus: req0 with rdata1=5, rdata2=7, ws=3.
  - Required: gnt0 in cycle 1; done0 in cycle 3 with res=12, res_ws=3; busy high in cycles 1–3; done1 never asserted.
- Simultaneous req0 and req1 held across three ops:
  - Required grants: 0, 1, 0.
  - Required done spacing is 3 cycles with no gap.
  - Rerun with `ALU_ARB_FIXED_PRIO_EN` defined: required grants 0, 0, 0.
- LAT=4:
  - Stimulus: req1 with rdata1=0xFFFFFFFF, rdata2=1.
  - Required: done1 in cycle 6 with res=0x00000000 (wrap).
  - Operand outputs stable during cycles 1–6.
- Requester changes its bundle after gnt, in cycle 2:
  - Required: res still reflects the captured operands.
- rst pulsed during WAIT:
  - Required: all outputs 0 the next cycle; no done pulse.
  - Required: a fresh req0 is granted normally afterwards.
- req1 held into its own DONE cycle:
  - Required: re-granted at that edge, with gnt1 in the cycle immediately after done1.
